// File: rtl/sme_pkg.sv
// Shared definitions for the sme_param string matcher: metacharacters, FSM
// states, pattern element kinds and the remaining-length helper.
package sme_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_START = 8'h5E;  // '^'
  localparam logic [7:0] CH_END   = 8'h24;  // '$'
  localparam logic [7:0] CH_ANY   = 8'h2E;  // '.'
  localparam logic [7:0] CH_STAR  = 8'h2A;  // '*', only special with SME_STAR_EN

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    EL_LIT   = 3'd0,
    EL_ANY   = 3'd1,
    EL_START = 3'd2,
    EL_END   = 3'd3,
    EL_STAR  = 3'd4
  } elem_t;

  // True when an attempt starting at offset s still has room for 'need'
  // consuming pattern characters.
  function automatic logic remaining_ok(input logic [15:0] s,
                                        input logic [15:0] str_len,
                                        input logic [15:0] need);
    return (s <= str_len) && ((str_len - s) >= need);
  endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Serial-load character buffer: write pointer, length, sticky overflow and
// restart-on-first-write after arm. Combinational read port.
module sme_char_buf #(
  parameter int CHAR_W = 8,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = $clog2(DEPTH + 1),
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              arm,
  input  logic              round_start,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_data,
  output logic [LEN_W-1:0]  len,
  output logic              ovf
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              ovf_reg, ovf_next;
  logic              fresh_reg, fresh_next;
  logic              we;
  logic [ADDR_W-1:0] waddr;

  always_comb begin
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    fresh_next = fresh_reg;
    we         = 1'b0;
    waddr      = '0;
    if (round_start) ovf_next = 1'b0;
    if (wr_en) begin
      if (fresh_reg) begin
        // first write after arm restarts the buffer
        we         = 1'b1;
        len_next   = LEN_W'(1);
        fresh_next = 1'b0;
      end else if (len_reg == DEPTH_L) begin
        ovf_next = 1'b1;
      end else begin
        we       = 1'b1;
        waddr    = len_reg[ADDR_W-1:0];
        len_next = len_reg + LEN_W'(1);
      end
    end
    if (arm) fresh_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg   <= '0;
      ovf_reg   <= 1'b0;
      fresh_reg <= 1'b1;
    end else begin
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
      fresh_reg <= fresh_next;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wr_data;
  end

  assign rd_data = (rd_addr < DEPTH_L) ? mem[rd_addr[ADDR_W-1:0]] : '0;
  assign len     = len_reg;
  assign ovf     = ovf_reg;

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine with '^' '$' '.' metacharacters.
// Define SME_STAR_EN to make the first '*' in a pattern match any run of chars.
module sme_param
  import sme_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 10,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              valid,
  output logic              busy,
  output logic              ovf
);

  // one spare count so offsets can run to str_len+1 without wrapping
  localparam int SL_W = $clog2(STR_MAX + 2);
  localparam int PL_W = $clog2(PAT_MAX + 2);
  localparam logic [PL_W-1:0]   PAT_MAX_L = PL_W'(PAT_MAX);
  localparam logic [CHAR_W-1:0] C_SPACE   = CHAR_W'(CH_SPACE);
  localparam logic [CHAR_W-1:0] C_START   = CHAR_W'(CH_START);
  localparam logic [CHAR_W-1:0] C_END     = CHAR_W'(CH_END);
  localparam logic [CHAR_W-1:0] C_ANY     = CHAR_W'(CH_ANY);
`ifdef SME_STAR_EN
  localparam logic [CHAR_W-1:0] C_STAR    = CHAR_W'(CH_STAR);
`endif

  state_t            state_reg, state_next;
  logic [SL_W-1:0]   s_reg, s_next, q_reg, q_next;
  logic [PL_W-1:0]   p_reg, p_next, need_reg, need_next;
  logic              pat_loaded_reg, pat_loaded_next;
  logic              round_open_reg, round_open_next;
  logic              match_reg, match_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
`ifdef SME_STAR_EN
  logic              star_set_reg, star_set_next;
  logic [PL_W-1:0]   star_p_reg, star_p_next;
  logic [SL_W-1:0]   star_q_reg, star_q_next;
  logic              star_seen_reg, star_seen_next;
  logic              in_star;
`endif

  logic              load_active, str_wr, pat_wr, round_start, arm, counted;
  logic [SL_W-1:0]   str_len, str_addr;
  logic [PL_W-1:0]   pat_len;
  logic [CHAR_W-1:0] str_char, pat_char;
  logic              str_ovf, pat_ovf;
  elem_t             elem;
  logic              elem_ok, consume;

  assign load_active = (state_reg == LOAD);
  assign str_wr      = load_active && isstring;
  assign pat_wr      = load_active && ispattern && !isstring;
  assign round_start = (str_wr || pat_wr) && !round_open_reg;
  assign arm         = (state_reg == DONE);

  sme_char_buf #(.CHAR_W(CHAR_W), .DEPTH(STR_MAX), .LEN_W(SL_W)) u_str_buf (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (str_wr),
    .wr_data     (chardata),
    .arm         (arm),
    .round_start (round_start),
    .rd_addr     (str_addr),
    .rd_data     (str_char),
    .len         (str_len),
    .ovf         (str_ovf)
  );

  sme_char_buf #(.CHAR_W(CHAR_W), .DEPTH(PAT_MAX), .LEN_W(PL_W)) u_pat_buf (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (pat_wr),
    .wr_data     (chardata),
    .arm         (arm),
    .round_start (round_start),
    .rd_addr     (p_reg),
    .rd_data     (pat_char),
    .len         (pat_len),
    .ovf         (pat_ovf)
  );

  // need_reg counts consuming pattern elements; anchors and the honoured star
  // take no string characters.
  always_comb begin
    counted = !(chardata == C_START || chardata == C_END);
`ifdef SME_STAR_EN
    in_star = (chardata == C_STAR);
    if (in_star && !(pat_loaded_reg && star_seen_reg)) counted = 1'b0;
    star_seen_next = star_seen_reg;
`endif
    need_next       = need_reg;
    pat_loaded_next = pat_loaded_reg;
    round_open_next = round_open_reg;
    if (round_start) round_open_next = 1'b1;
    if (pat_wr) begin
      pat_loaded_next = 1'b1;
      if (!pat_loaded_reg) begin
        need_next = PL_W'(counted);
`ifdef SME_STAR_EN
        star_seen_next = in_star;
`endif
      end else if (pat_len != PAT_MAX_L) begin
        need_next = need_reg + PL_W'(counted);
`ifdef SME_STAR_EN
        if (in_star) star_seen_next = 1'b1;
`endif
      end
    end
    if (arm) begin
      pat_loaded_next = 1'b0;
      round_open_next = 1'b0;
    end
  end

  always_comb begin
    elem = EL_LIT;
    if (pat_char == C_ANY)        elem = EL_ANY;
    else if (pat_char == C_START) elem = EL_START;
    else if (pat_char == C_END)   elem = EL_END;
`ifdef SME_STAR_EN
    else if (pat_char == C_STAR && !star_set_reg) elem = EL_STAR;
`endif
  end

  // '^' looks at the character before q, everything else at q itself
  assign str_addr = (elem == EL_START) ? (q_reg - SL_W'(1)) : q_reg;

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    q_next     = q_reg;
    p_next     = p_reg;
    match_next = match_reg;
    idx_next   = idx_reg;
    elem_ok    = 1'b0;
    consume    = 1'b0;
`ifdef SME_STAR_EN
    star_set_next = star_set_reg;
    star_p_next   = star_p_reg;
    star_q_next   = star_q_reg;
`endif
    case (state_reg)
      LOAD: begin
        if (!isstring && !ispattern && pat_loaded_reg) begin
          state_next = SCAN;
          s_next     = '0;
          q_next     = '0;
          p_next     = '0;
`ifdef SME_STAR_EN
          star_set_next = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (str_len == '0) begin
          state_next = DONE;
          match_next = 1'b0;
          idx_next   = '0;
        end else if (p_reg == pat_len) begin
          state_next = DONE;
          match_next = 1'b1;
          idx_next   = IDX_W'(s_reg);
        end else if (p_reg == '0 &&
                     !remaining_ok(16'(s_reg), 16'(str_len), 16'(need_reg))) begin
          state_next = DONE;
          match_next = 1'b0;
          idx_next   = '0;
        end else begin
          case (elem)
            EL_ANY: begin
              elem_ok = (q_reg < str_len);
              consume = 1'b1;
            end
            EL_START: elem_ok = (q_reg == '0) || (str_char == C_SPACE);
            EL_END:   elem_ok = (q_reg == str_len) || (str_char == C_SPACE);
`ifdef SME_STAR_EN
            EL_STAR: begin
              elem_ok       = 1'b1;
              star_set_next = 1'b1;
              star_p_next   = p_reg + PL_W'(1);
              star_q_next   = q_reg;
            end
`endif
            default: begin
              elem_ok = (q_reg < str_len) && (str_char == pat_char);
              consume = 1'b1;
            end
          endcase
          if (elem_ok) begin
            p_next = p_reg + PL_W'(1);
            if (consume) q_next = q_reg + SL_W'(1);
          end else begin
`ifdef SME_STAR_EN
            // let the star swallow one more character before giving up the offset
            if (star_set_reg && (star_q_reg < str_len)) begin
              star_q_next = star_q_reg + SL_W'(1);
              q_next      = star_q_reg + SL_W'(1);
              p_next      = star_p_reg;
            end else begin
              star_set_next = 1'b0;
              s_next        = s_reg + SL_W'(1);
              q_next        = s_reg + SL_W'(1);
              p_next        = '0;
            end
`else
            s_next = s_reg + SL_W'(1);
            q_next = s_reg + SL_W'(1);
            p_next = '0;
`endif
          end
        end
      end
      DONE:    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= LOAD;
      s_reg          <= '0;
      q_reg          <= '0;
      p_reg          <= '0;
      need_reg       <= '0;
      pat_loaded_reg <= 1'b0;
      round_open_reg <= 1'b0;
      match_reg      <= 1'b0;
      idx_reg        <= '0;
`ifdef SME_STAR_EN
      star_set_reg   <= 1'b0;
      star_p_reg     <= '0;
      star_q_reg     <= '0;
      star_seen_reg  <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      s_reg          <= s_next;
      q_reg          <= q_next;
      p_reg          <= p_next;
      need_reg       <= need_next;
      pat_loaded_reg <= pat_loaded_next;
      round_open_reg <= round_open_next;
      match_reg      <= match_next;
      idx_reg        <= idx_next;
`ifdef SME_STAR_EN
      star_set_reg   <= star_set_next;
      star_p_reg     <= star_p_next;
      star_q_reg     <= star_q_next;
      star_seen_reg  <= star_seen_next;
`endif
    end
  end

  assign match       = match_reg;
  assign match_index = idx_reg;
  assign valid       = (state_reg == DONE);
  assign busy        = (state_reg == SCAN) || (state_reg == DONE);
  assign ovf         = str_ovf || pat_ovf;

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: fixed string/pattern rounds with hand-computed
// results, overflow, string reuse and reset during a scan.
module tb_sme_param;

  localparam int CHAR_W  = 8;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 10;
  localparam int IDX_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [CHAR_W-1:0] chardata;
  logic              isstring, ispattern;
  logic              match, valid, busy, ovf;
  logic [IDX_W-1:0]  match_index;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sme_param #(.CHAR_W(CHAR_W), .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .match       (match),
    .match_index (match_index),
    .valid       (valid),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string txt, input bit is_str);
    for (int i = 0; i < txt.len(); i++) begin
      chardata  = txt[i];
      isstring  = is_str;
      ispattern = !is_str;
      tick();
    end
    isstring  = 1'b0;
    ispattern = 1'b0;
  endtask

  task automatic await_result(input string tag, output logic m,
                              output logic [IDX_W-1:0] ix, output logic o);
    bit got = 1'b0;
    m = 1'b0; ix = '0; o = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      tick();
      if (valid) begin
        got = 1'b1;
        m   = match;
        ix  = match_index;
        o   = ovf;
      end
    end
    if (!got) check({tag, ".timeout"}, 32'(got), 32'd1);
  endtask

  task automatic round(input string tag, input string str_txt, input string pat_txt,
                       input logic exp_m, input logic [IDX_W-1:0] exp_i, input logic exp_o);
    logic m, o;
    logic [IDX_W-1:0] ix;
    if (str_txt.len() != 0) send(str_txt, 1'b1);
    send(pat_txt, 1'b0);
    await_result(tag, m, ix, o);
    $display("round %s: pat=\"%s\" match=%0d index=%0d ovf=%0d", tag, pat_txt, m, ix, o);
    check({tag, ".match"}, 32'(m), 32'(exp_m));
    check({tag, ".index"}, 32'(ix), 32'(exp_i));
    check({tag, ".ovf"}, 32'(o), 32'(exp_o));
    tick();
    check({tag, ".valid_pulse"}, 32'(valid), 32'd0);
    check({tag, ".busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic m, o, seen;
    logic [IDX_W-1:0] ix;
    string long_str;

    reset = 1'b1; chardata = '0; isstring = 1'b0; ispattern = 1'b0;
    repeat (2) tick();
    check("reset.match", 32'(match), 32'd0);
    check("reset.index", 32'(match_index), 32'd0);
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    tick();

    round("hello", "hello world", "o w", 1'b1, 5'd4, 1'b0);
    round("cat_anch", "the cat", "^cat$", 1'b1, 5'd4, 1'b0);
    round("at_start", "", "^at", 1'b0, 5'd0, 1'b0);
    round("reuse_any", "", "c.t", 1'b1, 5'd4, 1'b0);
    round("reuse_dog", "", "dog", 1'b0, 5'd0, 1'b0);

    // 32 'a' then 3 'b': the 'b's must be dropped
    long_str = "";
    for (int i = 0; i < 32; i++) long_str = {long_str, "a"};
    long_str = {long_str, "bbb"};
    round("ovf", long_str, "b", 1'b0, 5'd0, 1'b1);

    // reuse the truncated string; first pattern char clears ovf
    chardata = "a"; ispattern = 1'b1; tick();
    check("ovf.clear", 32'(ovf), 32'd0);
    chardata = "$"; tick();
    ispattern = 1'b0;
    await_result("len32", m, ix, o);
    $display("round len32: pat=\"a$\" match=%0d index=%0d ovf=%0d", m, ix, o);
    check("len32.match", 32'(m), 32'd1);
    check("len32.index", 32'(ix), 32'd31);
    tick();

`ifdef SME_STAR_EN
    round("star", "abcxyzd", "b*d", 1'b1, 5'd1, 1'b0);
`else
    round("star", "abcxyzd", "b*d", 1'b0, 5'd0, 1'b0);
`endif

    // reset asserted in the middle of a scan
    send("hello world", 1'b1);
    send("zzz", 1'b0);
    tick();
    check("rst.busy_scan", 32'(busy), 32'd1);
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst.busy_now", 32'(busy), 32'd0);
    check("rst.valid_now", 32'(valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (valid) seen = 1'b1;
    end
    $display("reset mid-scan: valid seen=%0d", seen);
    check("rst.no_valid", 32'(seen), 32'd0);

    round("after_rst", "abc", "c", 1'b1, 5'd2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
